div4_seq: RTL and testbench

DIV4_SEQ -- requirements
Module: div4_seq

---
 rtl/div4_pkg.sv | 12 +
 rtl/addsub4b.sv | 18 +
 rtl/div4_seq.sv | 123 ++++++++++++
 tb/tb_div4_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/div4_pkg.sv
// Shared definitions for the 4-bit sequential restoring divider.
package div4_pkg;

    localparam int unsigned N_ITER = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub4b.sv
// 4-bit adder/subtractor: sum = a + b when s=0, a - b when s=1 (cout=1 means no borrow).
module addsub4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       s,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b ^ {4{s}}} + {4'b0000, s};
        sum  = full[3:0];
        cout = full[4];
    end

endmodule

// File: rtl/div4_seq.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per RUN cycle,
// zero divisor short-circuits straight to DONE with a flagged result.
module div4_seq
    import div4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    state_e     state_q, state_d;
    logic [3:0] r_q, r_d;
    logic [3:0] q_q, q_d;
    logic [3:0] d_q, d_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] quotient_q, quotient_d;
    logic [3:0] remainder_q, remainder_d;
    logic       dbz_q, dbz_d;

    logic [3:0] r_shift;
    logic [3:0] trial_diff;
    logic       trial_cout;
    logic       sub_ok;
    logic [3:0] q_step;
    logic [3:0] r_step;

    addsub4b u_trial (
        .a    (r_shift),
        .b    (d_q),
        .s    (1'b1),
        .sum  (trial_diff),
        .cout (trial_cout)
    );

    always_comb begin
        r_shift = {r_q[2:0], q_q[3]};
        // A bit shifted out of R means the 5-bit partial remainder exceeds any 4-bit divisor.
        sub_ok  = r_q[3] | trial_cout;
        q_step  = {q_q[2:0], sub_ok};
        r_step  = sub_ok ? trial_diff : r_shift;
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor == 4'd0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(N_ITER - 1)) begin
                    state_d     = DONE;
                    quotient_d  = q_step;
                    remainder_d = r_step;
                    dbz_d       = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
        busy        = (state_q == RUN);
        done        = (state_q == DONE);
    end

endmodule

// File: tb/tb_div4_seq.sv
// Self-checking bench for div4_seq against plain integer division.
module tb_div4_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    div4_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One division; hold_start re-asserts start with alternate operands while the DUT works.
    task automatic run_div(input int dvd, input int dvs, input bit hold_start,
                           input int alt_dvd, input int alt_dvs);
        int exp_q, exp_r, exp_dbz, exp_lat;
        int done_at, done_cnt, busy_cnt;
        int got_q, got_r, got_dbz;
        exp_q   = (dvs == 0) ? 15 : dvd / dvs;
        exp_r   = (dvs == 0) ? dvd : dvd % dvs;
        exp_dbz = (dvs == 0) ? 1 : 0;
        exp_lat = (dvs == 0) ? 0 : 4;

        @(negedge clk);
        start    = 1'b1;
        dividend = 4'(dvd);
        divisor  = 4'(dvs);
        @(posedge clk);
        #1;
        start = hold_start;
        if (hold_start) begin
            dividend = 4'(alt_dvd);
            divisor  = 4'(alt_dvs);
        end else begin
            dividend = 4'($urandom_range(15));
            divisor  = 4'($urandom_range(15));
        end

        done_at  = -1;
        done_cnt = 0;
        busy_cnt = 0;
        got_q    = 0;
        got_r    = 0;
        got_dbz  = 0;
        for (int n = 0; n <= 8; n++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    got_q   = int'(quotient);
                    got_r   = int'(remainder);
                    got_dbz = int'(div_by_zero);
                    start   = 1'b0;
                end
            end
            if (done_at >= 0 && n == done_at + 1) begin
                check_eq("q_hold", int'(quotient), exp_q);
                check_eq("r_hold", int'(remainder), exp_r);
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check_eq("done_latency", done_at, exp_lat);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("busy_cycles", busy_cnt, exp_lat);
        check_eq("quotient", got_q, exp_q);
        check_eq("remainder", got_r, exp_r);
        check_eq("div_by_zero", got_dbz, exp_dbz);
    endtask

    initial begin
        int dvd, dvs, seen_done, seen_busy;
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_quotient", int'(quotient), 0);
        check_eq("rst_remainder", int'(remainder), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        run_div(13, 4, 1'b0, 0, 0);
        run_div(15, 1, 1'b0, 0, 0);
        run_div(7, 9, 1'b0, 0, 0);
        run_div(9, 0, 1'b0, 0, 0);
        run_div(12, 5, 1'b1, 3, 1);

        // Reset lands on the second RUN edge of 14/3.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_quotient", int'(quotient), 0);
        check_eq("abort_remainder", int'(remainder), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        seen_busy = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        check_eq("abort_no_done", seen_done, 0);
        check_eq("abort_no_busy", seen_busy, 0);
        run_div(14, 3, 1'b0, 0, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(a, b, 1'b0, 0, 0);
            end
        end

        repeat (40) begin
            dvd = int'($urandom_range(15));
            dvs = int'($urandom_range(15));
            if (($urandom_range(3)) == 0) dvs = 0;
            if (($urandom_range(1)) == 0) begin
                repeat (int'($urandom_range(3))) @(posedge clk);
            end
            run_div(dvd, dvs, 1'($urandom_range(1)),
                    int'($urandom_range(15)), int'($urandom_range(15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
